load_store_unit: RTL and testbench

- Sits between the single-cycle datapath and the word-addressed data memory (32-bit words, synchronous read/write on `clk`).
- Translates byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses, including read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Provides a ready/done handshake so the datapath stalls while an access is in flight.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-addressed synchronous data memory
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN
module load_store_unit #(
   parameter int WORD_SIZE    = 32,
   parameter int ADDRESS_SIZE = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [ADDRESS_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]    req_wdata,
   output logic                    done,
   output logic                    err,
   output logic [WORD_SIZE-1:0]    load_data,
   output logic [ADDRESS_SIZE-1:0] Address,
   output logic [WORD_SIZE-1:0]    WriteData,
   output logic                    MemRead,
   output logic                    MemWrite,
   input  logic [WORD_SIZE-1:0]    ReadData
);

   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
   logic [1:0]              size_q, size_d;
   logic                    signed_q, signed_d;
   logic                    write_q, write_d;
   logic                    err_q, err_d;
   logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
   logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
   logic [WORD_SIZE-1:0]    load_data_q, load_data_d;

   logic                    illegal;
   logic [7:0]              rd_byte;
   logic [15:0]             rd_half;
   logic [WORD_SIZE-1:0]    extended;
   logic [WORD_SIZE-1:0]    merged;

   always_comb begin
      illegal = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_size == 2'b01 && req_addr[0])
         illegal = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
         illegal = 1'b1;
`endif
   end

   // Lane extraction and merge operate on the word returned during RD_WAIT
   always_comb begin
      case (addr_q[1:0])
         2'd0:    rd_byte = ReadData[7:0];
         2'd1:    rd_byte = ReadData[15:8];
         2'd2:    rd_byte = ReadData[23:16];
         default: rd_byte = ReadData[31:24];
      endcase
      rd_half = addr_q[1] ? ReadData[31:16] : ReadData[15:0];

      case (size_q)
         2'b00:   extended = {{24{signed_q & rd_byte[7]}}, rd_byte};
         2'b01:   extended = {{16{signed_q & rd_half[15]}}, rd_half};
         default: extended = ReadData;
      endcase

      merged = ReadData;
      if (size_q == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (size_q == 2'b01) begin
         if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
         else
            merged[15:0]  = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      signed_d    = signed_q;
      write_d     = write_q;
      err_d       = err_q;
      wdata_d     = wdata_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               size_d   = req_size;
               signed_d = req_signed;
               write_d  = req_write;
               wdata_d  = req_wdata;
               err_d    = illegal;
               if (illegal) begin
                  state_d = DONE;
               end else if (req_write && req_size == 2'b10) begin
                  mem_wdata_d = req_wdata;
                  state_d     = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:      state_d = RD_WAIT;
         RD_WAIT: begin
            if (write_q) begin
               mem_wdata_d = merged;
               state_d     = WR;
            end else begin
               load_data_d = extended;
               state_d     = DONE;
            end
         end
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         wdata_q     <= '0;
         mem_wdata_q <= '0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         write_q     <= write_d;
         err_q       <= err_d;
         wdata_q     <= wdata_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
      end
   end

   // Write strobe is gated by rst so an abort during WR never reaches memory
   assign req_ready = (state_q == IDLE);
   assign MemRead   = (state_q == RD);
   assign MemWrite  = (state_q == WR) && !rst;
   assign done      = (state_q == DONE);
   assign err       = (state_q == DONE) && err_q;
   assign Address   = {2'b00, addr_q[ADDRESS_SIZE-1:2]};
   assign WriteData = mem_wdata_q;
   assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_init = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        done, err;
   logic [31:0] load_data, Address, WriteData, ReadData;
   logic        MemRead, MemWrite;

   logic [31:0] mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   int          done_cyc, rd_cnt, wr_cnt, both_cnt;
   logic [31:0] rd_addr, wr_data;
   logic        err_seen, rdy_issue, rdy_in_done;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam logic [31:0] MEM4_AFTER_MIS = 32'h01234567;
`else
   localparam logic [31:0] MEM4_AFTER_MIS = 32'h0123CAFE;
`endif

   load_store_unit #(.WORD_SIZE(32), .ADDRESS_SIZE(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .done(done), .err(err), .load_data(load_data),
      .Address(Address), .WriteData(WriteData), .MemRead(MemRead),
      .MemWrite(MemWrite), .ReadData(ReadData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[2] <= 32'h7F801234;
         mem[4] <= 32'h8899AABB;
         ReadData <= 32'h0;
      end else begin
         if (MemWrite) mem[Address[3:0]] <= WriteData;
         if (MemRead)  ReadData <= mem[Address[3:0]];
      end
   end

   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      rdy_issue  = req_ready;
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      done_cyc = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      rd_addr = '0; wr_data = '0; err_seen = 1'b0; rdy_in_done = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (MemRead)  begin rd_cnt++; rd_addr = Address; end
         if (MemWrite) begin wr_cnt++; wr_data = WriteData; end
         if (MemRead && MemWrite) both_cnt++;
         if (done) begin
            done_cyc = c; err_seen = err; rdy_in_done = req_ready;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; mem_init = 1'b0;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
      n_checks++; if ({done, err, MemRead, MemWrite} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes got %b want 0000", {done, err, MemRead, MemWrite}); end
      n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load_data got %h want 0", load_data); end
      n_checks++; if (Address !== 32'h0 || WriteData !== 32'h0) begin n_fail++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", Address, WriteData); end
   endtask

   task automatic test_load_byte;
      run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      n_checks++; if (done_cyc !== 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", done_cyc); end
      n_checks++; if (load_data !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_data got %h want ffffffaa", load_data); end
      n_checks++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL lb_err got %b want 0", err_seen); end
      n_checks++; if (rdy_in_done !== 1'b0) begin n_fail++; $display("FAIL ready_in_done got %b want 0", rdy_in_done); end
      run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      n_checks++; if (load_data !== 32'h000000AA) begin n_fail++; $display("FAIL lbu_data got %h want 000000aa", load_data); end
   endtask

   task automatic test_load_half_word;
      run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      n_checks++; if (load_data !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_data got %h want ffff8899", load_data); end
      run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
      n_checks++; if (load_data !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_data got %h want 8899aabb", load_data); end
      n_checks++; if (rd_cnt !== 1 || rd_addr !== 32'h4) begin n_fail++; $display("FAIL lw_memread got cnt %0d addr %h want 1/4", rd_cnt, rd_addr); end
      n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL lw_memwrite got %0d want 0", wr_cnt); end
   endtask

   task automatic test_store_byte;
      run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055);
      n_checks++; if (done_cyc !== 4) begin n_fail++; $display("FAIL sb_latency got %0d want 4", done_cyc); end
      n_checks++; if (wr_data !== 32'h5599AABB) begin n_fail++; $display("FAIL sb_wdata got %h want 5599aabb", wr_data); end
      n_checks++; if (rd_cnt !== 1 || wr_cnt !== 1 || both_cnt !== 0) begin n_fail++; $display("FAIL sb_strobes got rd %0d wr %0d both %0d want 1/1/0", rd_cnt, wr_cnt, both_cnt); end
      n_checks++; if (mem[4] !== 32'h5599AABB) begin n_fail++; $display("FAIL sb_mem got %h want 5599aabb", mem[4]); end
   endtask

   task automatic test_store_word;
      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h01234567);
      n_checks++; if (done_cyc !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", done_cyc); end
      n_checks++; if (mem[4] !== 32'h01234567) begin n_fail++; $display("FAIL sw_mem got %h want 01234567", mem[4]); end
      n_checks++; if (rd_cnt !== 0 || wr_cnt !== 1) begin n_fail++; $display("FAIL sw_strobes got rd %0d wr %0d want 0/1", rd_cnt, wr_cnt); end
   endtask

   task automatic test_illegal;
      run_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0);
      n_checks++; if (done_cyc !== 1 || err_seen !== 1'b1) begin n_fail++; $display("FAIL illegal_done got cyc %0d err %b want 1/1", done_cyc, err_seen); end
      n_checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_fail++; $display("FAIL illegal_strobes got rd %0d wr %0d want 0/0", rd_cnt, wr_cnt); end
      n_checks++; if (load_data !== 32'h8899AABB) begin n_fail++; $display("FAIL illegal_load_data got %h want 8899aabb", load_data); end
      @(negedge clk);
      n_checks++; if (err !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got err %b done %b want 0/0", err, done); end
   endtask

   task automatic test_misalign;
      run_req(1'b1, 2'b01, 1'b0, 32'h11, 32'hDEADCAFE);
`ifdef LSU_MISALIGN_TRAP_EN
      n_checks++; if (done_cyc !== 1 || err_seen !== 1'b1) begin n_fail++; $display("FAIL mis_trap got cyc %0d err %b want 1/1", done_cyc, err_seen); end
      n_checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_fail++; $display("FAIL mis_strobes got rd %0d wr %0d want 0/0", rd_cnt, wr_cnt); end
`else
      n_checks++; if (done_cyc !== 4 || err_seen !== 1'b0) begin n_fail++; $display("FAIL mis_store got cyc %0d err %b want 4/0", done_cyc, err_seen); end
      n_checks++; if (wr_data !== 32'h0123CAFE) begin n_fail++; $display("FAIL mis_wdata got %h want 0123cafe", wr_data); end
`endif
      n_checks++; if (mem[4] !== MEM4_AFTER_MIS) begin n_fail++; $display("FAIL mis_mem got %h want %h", mem[4], MEM4_AFTER_MIS); end
   endtask

   task automatic test_back_to_back;
      run_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
      n_checks++; if (load_data !== 32'h0000007F) begin n_fail++; $display("FAIL b2b_first got %h want 0000007f", load_data); end
      run_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
      n_checks++; if (rdy_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", rdy_issue); end
      n_checks++; if (done_cyc !== 3 || load_data !== 32'h00007F80) begin n_fail++; $display("FAIL b2b_second got cyc %0d data %h want 3/00007f80", done_cyc, load_data); end
      run_req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0);
      n_checks++; if (load_data !== 32'h00001234) begin n_fail++; $display("FAIL b2b_third got %h want 00001234", load_data); end
   endtask

   task automatic test_reset_during_write;
      logic seen_wr;
      seen_wr = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h00000077;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (MemWrite) begin seen_wr = 1'b1; break; end
      end
      n_checks++; if (seen_wr !== 1'b1) begin n_fail++; $display("FAIL rstwr_reach_wr got %b want 1", seen_wr); end
      rst = 1'b1;
      #1;
      n_checks++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL rstwr_gate got %b want 0", MemWrite); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (mem[4] !== MEM4_AFTER_MIS) begin n_fail++; $display("FAIL rstwr_mem got %h want %h", mem[4], MEM4_AFTER_MIS); end
      n_checks++; if (req_ready !== 1'b1 || {done, err, MemRead, MemWrite} !== 4'b0000) begin n_fail++; $display("FAIL rstwr_ctrl got ready %b strobes %b want 1/0000", req_ready, {done, err, MemRead, MemWrite}); end
      n_checks++; if (load_data !== 32'h0 || Address !== 32'h0 || WriteData !== 32'h0) begin n_fail++; $display("FAIL rstwr_data got %h/%h/%h want 0/0/0", load_data, Address, WriteData); end
   endtask

   initial begin
      test_reset;
      test_load_byte;
      test_load_half_word;
      test_store_byte;
      test_store_word;
      test_illegal;
      test_misalign;
      test_back_to_back;
      test_reset_during_write;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
